// File: rtl/sched_pkg.sv
// Shared constants and FSM state encoding for the round-robin word scheduler.
package sched_pkg;

  localparam int NCH_DEF       = 16;
  localparam int W_DEF         = 16;
  localparam int SELW_DEF      = 4;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request strictly after 'last', wrapping,
// with 'last' itself checked at lowest priority.
module rr_pick #(
  parameter int NCH  = 16,
  parameter int SELW = 4
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;

  // Scan farthest offset first so the nearest requester after 'last' overwrites and wins.
  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int i = NCH; i >= 1; i--) begin
      cand = last + SELW'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_word_scheduler.sv
// Round-robin scheduler driving a 16:1 word mux, capturing the word with valid/ready and acking
// the source. Optional SCHED_BURST_EN lets a grant stream up to BURST_MAX words back to back.
module rr_word_scheduler
  import sched_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int W         = W_DEF,
`ifdef SCHED_BURST_EN
  parameter int BURST_MAX = BURST_MAX_DEF,
`endif
  parameter int SELW      = SELW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  output logic [SELW-1:0] sel,
  input  logic [W-1:0]    mux_data,
  output logic [NCH-1:0]  ack,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;

`ifdef SCHED_BURST_EN
  localparam int BCW = ($clog2(BURST_MAX) > 0) ? $clog2(BURST_MAX) : 1;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
`endif

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = '0;
`ifdef SCHED_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A source that withdrew between grant and capture forfeits without moving the pointer.
        if (req[sel_q]) begin
          out_data_d  = mux_data;
          out_valid_d = 1'b1;
          ack_d       = {{(NCH-1){1'b0}}, 1'b1} << sel_q;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef SCHED_BURST_EN
          if (req[sel_q] && (burst_cnt_q < BCW'(BURST_MAX - 1))) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            state_d     = ST_CAPTURE;
          end else begin
            last_d      = sel_q;
            burst_cnt_d = '0;
            state_d     = ST_IDLE;
          end
`else
          last_d  = sel_q;
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      last_q      <= SELW'(NCH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_q       <= '0;
`ifdef SCHED_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_q       <= ack_d;
`ifdef SCHED_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_word_scheduler.sv
// Self-checking bench for rr_word_scheduler: directed steps plus randomized request patterns
// checked against a transaction-level round-robin model.
module tb_rr_word_scheduler;

  localparam int BMAX = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  sel;
  logic [15:0] mux_data;
  logic [15:0] ack;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] words [16];

  int total = 0;
  int bad   = 0;

  // Reference model state: pointer of last completed grant and burst bookkeeping.
  int last_m;
  int burst_m;
  bit pend_same;
  int prev_ch;

  assign mux_data = words[sel];

  rr_word_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .mux_data  (mux_data),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [15:0] r, input int last);
    for (int i = 1; i <= 16; i++) begin
      if (r[(last + i) % 16]) return (last + i) % 16;
    end
    return -1;
  endfunction

  task automatic new_words();
    for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    step();
    rst       = 1'b0;
    last_m    = 15;
    burst_m   = 0;
    pend_same = 1'b0;
  endtask

  // One full word transfer: wait for the ack, hold for 'hold' cycles, then hand off.
  task automatic run_word(input int hold, output int got);
    int          exp_ch;
    int          n;
    logic [15:0] exp_ack;
    logic [15:0] cap;
    exp_ch  = pend_same ? prev_ch : pick(req, last_m);
    exp_ack = 16'h0001 << exp_ch;
    n = 0;
    do begin
      step();
      n++;
    end while (ack === 16'h0000 && n < 8);
    got = int'(sel);
    check("ack_onehot", 32'(ack), 32'(exp_ack));
    check("grant_sel", 32'(sel), 32'(exp_ch));
    check("cap_valid", 32'(out_valid), 32'd1);
    check("cap_data", 32'(out_data), 32'(words[exp_ch]));
    cap = out_data;
    repeat (hold) begin
      step();
      check("hold_data", 32'(out_data), 32'(cap));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ack", 32'(ack), 32'd0);
      check("hold_sel", 32'(sel), 32'(exp_ch));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_ack", 32'(ack), 32'd0);
`ifdef SCHED_BURST_EN
    if (req[exp_ch] && burst_m < BMAX - 1) begin
      burst_m++;
      pend_same = 1'b1;
      prev_ch   = exp_ch;
    end else begin
      last_m    = exp_ch;
      burst_m   = 0;
      pend_same = 1'b0;
    end
`else
    last_m = exp_ch;
`endif
  endtask

  initial begin
    int          got;
    logic [15:0] r;
    new_words();

    // Reset values, then single-request latency on channel 0.
    do_reset();
    req = 16'h0001;
    step();
    check("lat_sel", 32'(sel), 32'd0);
    check("lat_valid_early", 32'(out_valid), 32'd0);
    check("lat_ack_early", 32'(ack), 32'd0);
    step();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_ack", 32'(ack), 32'h0001);
    check("lat_data", 32'(out_data), 32'(words[0]));
    req       = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("lat_hs_valid", 32'(out_valid), 32'd0);

    // All channels requesting: strict rotation 0..15 then wrap to 0.
    do_reset();
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      run_word(0, got);
`ifdef SCHED_BURST_EN
      check("rr_order", 32'(got), 32'((i / BMAX) % 16));
`else
      check("rr_order", 32'(got), 32'(i % 16));
`endif
    end

    // Wrap from pointer 15 to channel 0, then on to 15.
    do_reset();
    req = 16'h8001;
    run_word(1, got);
    check("wrap_first", 32'(got), 32'd0);
`ifdef SCHED_BURST_EN
    repeat (BMAX - 1) run_word(0, got);
`endif
    run_word(0, got);
    check("wrap_second", 32'(got), 32'd15);

    // Long backpressure in HOLD.
    do_reset();
    req = 16'h0020;
    run_word(10, got);
    check("bp_ch", 32'(got), 32'd5);

    // Request withdrawn during CAPTURE: no capture, pointer untouched.
    do_reset();
    req = 16'h0010;
    step();
    check("drop_sel", 32'(sel), 32'd4);
    req = '0;
    step();
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_ack", 32'(ack), 32'd0);
    step();
    check("drop_idle_ack", 32'(ack), 32'd0);
    req = 16'h0011;
    run_word(0, got);
    check("drop_pointer", 32'(got), 32'd0);

    // Asynchronous reset in HOLD.
    req = 16'h0008;
    step();
    step();
    check("hold_pre_rst_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_ack", 32'(ack), 32'd0);
    check("async_sel", 32'(sel), 32'd0);
    step();
    rst       = 1'b0;
    last_m    = 15;
    burst_m   = 0;
    pend_same = 1'b0;
    req       = 16'hFFFF;
    run_word(0, got);
    check("post_rst_ch", 32'(got), 32'd0);

    // Single held request: bursts of one channel, then re-arbitration.
    do_reset();
    req = 16'h0004;
    for (int i = 0; i < BMAX; i++) begin
      run_word(0, got);
      check("burst_ch", 32'(got), 32'd2);
    end
    req = 16'h0014;
    run_word(0, got);
    check("burst_rearb", 32'(got), 32'd4);

    // Randomized request patterns and backpressure against the model.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (!pend_same) begin
        r = 16'($urandom);
        if (r == 16'h0000) r = 16'h0001 << $urandom_range(0, 15);
        req = r;
        new_words();
      end
      run_word(int'($urandom_range(0, 3)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
